// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming(7,4) serial receive path.
package hamming_pkg;

  localparam int CW_W  = 7;
  localparam int NIB_W = 4;

  // Bit positions inside a codeword, wire order LSB first
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int D0 = 2;
  localparam int P4 = 3;
  localparam int D1 = 4;
  localparam int D2 = 5;
  localparam int D3 = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CW0  = 2'd1,
    CW1  = 2'd2
  } state_t;

  function automatic logic [2:0] calc_syndrome(input logic [CW_W-1:0] cw);
    calc_syndrome = {cw[P4] ^ cw[D1] ^ cw[D2] ^ cw[D3],
                     cw[P2] ^ cw[D0] ^ cw[D2] ^ cw[D3],
                     cw[P1] ^ cw[D0] ^ cw[D1] ^ cw[D3]};
  endfunction

endpackage

// File: rtl/hamming_stream_rx_correct.sv
// Combinational single-error corrector for one Hamming(7,4) codeword.
module hamming74_correct
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]  cw,
  output logic [NIB_W-1:0] nibble,
  output logic [2:0]       syndrome,
  output logic             err
);

  logic [NIB_W-1:0] raw_nib_s;

  // Syndrome decode and data-bit flip; parity-bit errors leave data untouched
  always_comb begin
    syndrome  = calc_syndrome(cw);
    err       = (syndrome != 3'd0);
    raw_nib_s = {cw[D3], cw[D2], cw[D1], cw[D0]};
    case (syndrome)
      3'd3:    nibble = raw_nib_s ^ 4'b0001;
      3'd5:    nibble = raw_nib_s ^ 4'b0010;
      3'd6:    nibble = raw_nib_s ^ 4'b0100;
      3'd7:    nibble = raw_nib_s ^ 4'b1000;
      default: nibble = raw_nib_s;
    endcase
  end

endmodule

// File: rtl/hamming_stream_rx.sv
// Serial Hamming(7,4) receiver: deframes two codewords per byte, corrects
// single-bit errors and holds the byte in a one-entry valid/ready register.
module hamming_stream_rx
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic             s_bit,
  input  logic             s_sof,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_corrected,
  output logic [CNT_W-1:0] err_count,
  output logic             overflow,
  output logic             resync
);

  state_t           state_r, state_nxt_s;
  logic [2:0]       cnt_r, cnt_nxt_s;
  logic [5:0]       shift_r;
  logic [NIB_W-1:0] lo_nib_r, nib_s;
  logic             lo_err_r, err_s;
  logic [2:0]       syn_s;
  logic             cw_done_s, byte_done_s, resync_s, load_s;

  // The bit on the wire this cycle completes the codeword together with the shifter
  hamming74_correct u_correct (
    .cw       ({s_bit, shift_r}),
    .nibble   (nib_s),
    .syndrome (syn_s),
    .err      (err_s)
  );

  // Frame FSM next-state and bit counter
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    cw_done_s   = 1'b0;
    byte_done_s = 1'b0;
    resync_s    = 1'b0;
    if (s_valid) begin
      if (s_sof) begin
        state_nxt_s = CW0;
        cnt_nxt_s   = 3'd1;
        resync_s    = (state_r != IDLE);
      end else begin
        case (state_r)
          IDLE: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 3'd0;
          end
          CW0: begin
            if (cnt_r == 3'd6) begin
              cw_done_s   = 1'b1;
              state_nxt_s = CW1;
              cnt_nxt_s   = 3'd0;
            end else begin
              cnt_nxt_s = cnt_r + 3'd1;
            end
          end
          CW1: begin
            if (cnt_r == 3'd6) begin
              cw_done_s   = 1'b1;
              byte_done_s = 1'b1;
              state_nxt_s = IDLE;
              cnt_nxt_s   = 3'd0;
            end else begin
              cnt_nxt_s = cnt_r + 3'd1;
            end
          end
          default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 3'd0;
          end
        endcase
      end
    end else begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
    end
    load_s = byte_done_s && (!m_valid || m_ready);
  end

  // Frame state, shifter, low-nibble holding and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 3'd0;
      shift_r   <= 6'd0;
      lo_nib_r  <= 4'd0;
      lo_err_r  <= 1'b0;
      resync    <= 1'b0;
      err_count <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      resync  <= resync_s;
      if (s_valid) begin
        shift_r <= {s_bit, shift_r[5:1]};
      end
      if (cw_done_s && (state_r == CW0)) begin
        lo_nib_r <= nib_s;
        lo_err_r <= err_s;
      end
      if (cw_done_s && (syn_s != 3'd0) && (err_count != {CNT_W{1'b1}})) begin
        err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // One-entry output register; a byte finishing while the slot is blocked is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data      <= 8'd0;
      m_valid     <= 1'b0;
      m_corrected <= 1'b0;
      overflow    <= 1'b0;
    end else if (load_s) begin
      m_data      <= {nib_s, lo_nib_r};
      m_corrected <= lo_err_r | err_s;
      m_valid     <= 1'b1;
    end else if (byte_done_s) begin
      overflow <= 1'b1;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hamming_stream_rx.sv
// Directed and randomized bench for hamming_stream_rx against a bit-queue model.
module tb_hamming_stream_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0, s_bit = 1'b0, s_sof = 1'b0, m_ready = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid, m_corrected, overflow, resync;
  logic [15:0] err_count;

  int n_total = 0, n_bad = 0, resync_seen = 0;

  // Reference state: collected frame bits plus the visible output register
  logic        mq[$];
  logic [3:0]  m_lo;
  logic        m_lo_err;
  logic [7:0]  e_data;
  logic        e_valid, e_corr, e_ovf, e_resync;
  logic [15:0] e_err;

  hamming_stream_rx #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_bit(s_bit), .s_sof(s_sof),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_corrected(m_corrected),
    .err_count(err_count), .overflow(overflow), .resync(resync)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Syndrome as the XOR of the 1-based positions of all set bits
  function automatic int model_syn(input logic [6:0] cw);
    int s = 0;
    for (int i = 0; i < 7; i++) if (cw[i]) s = s ^ (i + 1);
    return s;
  endfunction

  function automatic logic [3:0] model_data(input logic [6:0] cw);
    logic [6:0] c = cw;
    int s = model_syn(cw);
    if (s != 0) c[s-1] = ~c[s-1];
    return {c[6], c[5], c[4], c[2]};
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] c;
    for (int v = 0; v < 128; v++) begin
      c = 7'(v);
      if (model_syn(c) == 0 && {c[6], c[5], c[4], c[2]} == d) return c;
    end
    return 7'd0;
  endfunction

  task automatic check_outputs(input string ph);
    check_eq({ph, "_valid"}, m_valid, e_valid);
    check_eq({ph, "_data"}, m_data, e_data);
    check_eq({ph, "_corr"}, m_corrected, e_corr);
    check_eq({ph, "_errcnt"}, err_count, e_err);
    check_eq({ph, "_ovf"}, overflow, e_ovf);
    check_eq({ph, "_resync"}, resync, e_resync);
  endtask

  task automatic model_clear();
    mq.delete();
    m_lo = 4'd0; m_lo_err = 1'b0;
    e_data = 8'd0; e_valid = 1'b0; e_corr = 1'b0; e_ovf = 1'b0; e_resync = 1'b0; e_err = 16'd0;
  endtask

  task automatic do_reset();
    s_valid = 1'b0; s_bit = 1'b0; s_sof = 1'b0; m_ready = 1'b0;
    rst = 1'b1;
    #3;
    model_clear();
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    resync_seen = 0;
  endtask

  task automatic step(input logic v, input logic b, input logic sof, input logic rdy);
    logic [6:0] cw;
    logic [7:0] nb;
    logic       nc, fin;
    int         s;
    s_valid = v; s_bit = b; s_sof = sof; m_ready = rdy;
    @(posedge clk);
    e_resync = 1'b0; fin = 1'b0; nb = 8'd0; nc = 1'b0;
    if (v) begin
      if (sof) begin
        if (mq.size() != 0) e_resync = 1'b1;
        mq.delete();
        mq.push_back(b);
      end else if (mq.size() != 0) begin
        mq.push_back(b);
      end
      if (mq.size() == 7 || mq.size() == 14) begin
        for (int i = 0; i < 7; i++) cw[i] = mq[mq.size() - 7 + i];
        s = model_syn(cw);
        if (s != 0 && e_err != 16'hFFFF) e_err = e_err + 16'd1;
        if (mq.size() == 7) begin
          m_lo = model_data(cw); m_lo_err = (s != 0);
        end else begin
          nb = {model_data(cw), m_lo}; nc = m_lo_err || (s != 0); fin = 1'b1;
          mq.delete();
        end
      end
    end
    if (fin) begin
      if (!e_valid || rdy) begin
        e_data = nb; e_corr = nc; e_valid = 1'b1;
      end else begin
        e_ovf = 1'b1;
      end
    end else if (e_valid && rdy) begin
      e_valid = 1'b0;
    end
    #1;
    if (resync === 1'b1) resync_seen++;
    check_outputs("cyc");
  endtask

  function automatic logic rdy_val(input int mode);
    if (mode == 2) return ($urandom_range(0, 3) != 0);
    return (mode != 0);
  endfunction

  // Sends nbits of a codeword LSB first; optional idle gaps before each bit
  task automatic send_cw(input logic [6:0] cw, input logic sof_first, input int rdy_mode,
                         input int last_rdy_mode, input int nbits, input int gaps);
    for (int i = 0; i < nbits; i++) begin
      if (gaps > 0) begin
        for (int g = $urandom_range(0, gaps); g > 0; g--) step(1'b0, 1'($urandom), 1'b0, rdy_val(rdy_mode));
      end
      step(1'b1, cw[i], sof_first && (i == 0), rdy_val(i == 6 ? last_rdy_mode : rdy_mode));
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic [6:0] c0, c1;
    int r;
    model_clear();

    // Clean 0xA5
    do_reset();
    send_cw(7'h2D, 1'b1, 1, 1, 7, 0);
    check_eq("clean_prelast_valid", m_valid, 1'b0);
    send_cw(7'h52, 1'b0, 1, 1, 7, 0);
    check_eq("clean_data", m_data, 8'hA5);
    check_eq("clean_valid", m_valid, 1'b1);
    check_eq("clean_corr", m_corrected, 1'b0);
    check_eq("clean_err", err_count, 16'd0);

    // Data-bit error in CW0
    do_reset();
    send_cw(7'h29, 1'b1, 1, 1, 7, 0);
    send_cw(7'h52, 1'b0, 1, 1, 7, 0);
    check_eq("derr_data", m_data, 8'hA5);
    check_eq("derr_corr", m_corrected, 1'b1);
    check_eq("derr_err", err_count, 16'd1);

    // Parity-bit errors in both codewords
    do_reset();
    send_cw(7'h2C, 1'b1, 1, 1, 7, 0);
    send_cw(7'h53, 1'b0, 1, 1, 7, 0);
    check_eq("perr_data", m_data, 8'hA5);
    check_eq("perr_corr", m_corrected, 1'b1);
    check_eq("perr_err", err_count, 16'd2);

    // Backpressure: second byte dropped
    do_reset();
    send_cw(7'h2D, 1'b1, 0, 0, 7, 0); send_cw(7'h52, 1'b0, 0, 0, 7, 0);
    send_cw(7'h52, 1'b1, 0, 0, 7, 0); send_cw(7'h2D, 1'b0, 0, 0, 7, 0);
    check_eq("bp_data", m_data, 8'hA5);
    check_eq("bp_ovf", overflow, 1'b1);
    check_eq("bp_valid", m_valid, 1'b1);

    // Backpressure released on the completing bit: back-to-back load
    do_reset();
    send_cw(7'h2D, 1'b1, 0, 0, 7, 0); send_cw(7'h52, 1'b0, 0, 0, 7, 0);
    send_cw(7'h52, 1'b1, 0, 0, 7, 0); send_cw(7'h2D, 1'b0, 0, 1, 7, 0);
    check_eq("b2b_data", m_data, 8'h5A);
    check_eq("b2b_ovf", overflow, 1'b0);
    check_eq("b2b_valid", m_valid, 1'b1);

    // Resync at CW1 bit 3
    do_reset();
    send_cw(7'h2D, 1'b1, 1, 1, 7, 0); send_cw(7'h52, 1'b0, 1, 1, 3, 0);
    send_cw(7'h52, 1'b1, 1, 1, 7, 0); send_cw(7'h2D, 1'b0, 1, 1, 7, 0);
    check_eq("rs_pulses", resync_seen, 1);
    check_eq("rs_data", m_data, 8'h5A);
    check_eq("rs_valid", m_valid, 1'b1);

    // Gaps inside the frame
    do_reset();
    send_cw(7'h2D, 1'b1, 1, 1, 7, 3); send_cw(7'h52, 1'b0, 1, 1, 7, 3);
    check_eq("gap_data", m_data, 8'hA5);
    check_eq("gap_valid", m_valid, 1'b1);

    // Reset at CW0 bit 4, then the remaining bits must be ignored
    do_reset();
    send_cw(7'h2D, 1'b1, 1, 1, 4, 0);
    s_valid = 1'b1; s_bit = 1'b0; s_sof = 1'b0;
    do_reset();
    for (int i = 4; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    send_cw(7'h52, 1'b0, 1, 1, 7, 0);
    check_eq("abort_valid", m_valid, 1'b0);
    check_eq("abort_data", m_data, 8'h00);

    // Randomized frames, errors, aborts, noise and backpressure
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rb = 8'($urandom);
      c0 = enc(rb[3:0]); c1 = enc(rb[7:4]);
      r = $urandom_range(0, 9);
      if (r < 4) c0[$urandom_range(0, 6)] ^= 1'b1;
      if (r == 9) begin c0[0] ^= 1'b1; c0[$urandom_range(1, 6)] ^= 1'b1; end
      r = $urandom_range(0, 9);
      if (r < 4) c1[$urandom_range(0, 6)] ^= 1'b1;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        for (int k = 0; k < 3; k++) step(1'b1, 1'($urandom), 1'b0, rdy_val(2));
      end else if (r == 1) begin
        send_cw(c0, 1'b1, 2, 2, $urandom_range(1, 6), 1);
      end
      send_cw(c0, 1'b1, 2, 2, 7, $urandom_range(0, 1));
      send_cw(c1, 1'b0, 2, 2, 7, $urandom_range(0, 1));
    end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("final_drain", m_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/hamming_stream_rx.md
# hamming_stream_rx

Serial receive-side Hamming(7,4) decoder for the on-board error-protected bit link. Accepts one code bit per cycle, deframes two 7-bit codewords per byte, corrects any single-bit error in each codeword, and presents the corrected byte on a one-entry valid/ready output register. Sits between the link deserializer front end and the byte consumer. Keeps running error statistics.

## Interface
- CNT_W, 16: width of the corrected-error counter.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  s_bit is a valid code bit this cycle.
- s_bit  in  1  serial code bit.
- s_sof  in  1  qualified by s_valid; marks bit 0 of a byte's first codeword.
- m_data  out  8  corrected byte; [3:0] from codeword 0, [7:4] from codeword 1.
- m_valid  out  1  m_data holds an unconsumed byte.
- m_ready  in  1  consumer accepts m_data when m_valid && m_ready.
- m_corrected  out  1  a nonzero syndrome occurred in either codeword of m_data.
- err_count  out  CNT_W  codewords with nonzero syndrome since reset; saturating.
- overflow  out  1  sticky: a completed byte was dropped.
- resync  out  1  one-cycle pulse: s_sof arrived mid-frame.

## Operation
- Codeword bit order on the wire is LSB first, bit 0 through bit 6.
- Codeword layout: [0]=p1, [1]=p2, [2]=d0, [3]=p4, [4]=d1, [5]=d2, [6]=d3.
- Syndrome: s0=c0^c2^c4^c6, s1=c1^c2^c5^c6, s2=c3^c4^c5^c6.
- S={s2,s1,s0} names the erroneous bit index S-1.
- Correction: S=3 flips d0, S=5 flips d1, S=6 flips d2, S=7 flips d3.
- S=1, 2 or 4: the error is in a parity bit; data passes unchanged, but the codeword is still counted as corrected.
- Double-bit errors are not detected; the block miscorrects them silently.
- FSM states:
  - IDLE: waits for s_valid && s_sof; that bit is bit 0 of CW0; go to CW0.
  - CW0: collects bits 1..6 with a 3-bit counter (0..6). On bit 6, decode, store the low nibble and its error flag, go to CW1.
  - CW1: collects bits 0..6. On bit 6, decode and form the byte, go to IDLE.
- Cycles with s_valid low do not advance the counter or state.
- s_sof with s_valid in CW0 or CW1 discards the partial frame, pulses resync, and restarts at CW0 with that bit as bit 0.
- s_sof in IDLE is the normal start of frame; resync does not pulse.
- s_sof on a bit other than bit 0 in IDLE is not possible, because IDLE ignores bits without s_sof.
- err_count increments once per codeword with S!=0, on that codeword's last bit. This includes codewords in dropped or aborted frames. It saturates at all-ones.
- Output register on byte completion:
  - If m_valid==0 or m_ready==1 that cycle, load m_data and m_corrected and set m_valid.
  - Otherwise drop the new byte and set overflow; m_data is unchanged.
- A handshake with no completion clears m_valid.
- overflow clears only on rst.

## Timing
- Reset: state IDLE, counter 0, m_data 0, m_valid 0, m_corrected 0, err_count 0, overflow 0, resync 0.
- Latency: m_valid rises the cycle after the clock edge that samples CW1 bit 6.
- Minimum frame is 14 consecutive valid cycles; sustained throughput is one byte per 14 valid bits.
- A completion and a handshake in the same cycle yield back-to-back bytes with m_valid held high.
- err_count and resync update on the edge that samples the triggering bit.
- rst mid-frame aborts the frame immediately; the next byte needs a fresh s_sof.
- m_data, m_valid and m_corrected hold stable while m_valid && !m_ready.

## Structure
- Shared package hamming_pkg:
  - CW_W=7 and NIB_W=4.
  - Codeword bit-position constants (P1, P2, D0, P4, D1, D2, D3).
  - State enum {IDLE, CW0, CW1}.
- Sub-module hamming74_correct, purely combinational: 7-bit codeword in; corrected nibble, syndrome and error flag out. One instance, fed by {s_bit, shift[5:0]}.

## Test plan
- Clean byte 0xA5: send CW0=7'h2D then CW1=7'h52, LSB first, with s_sof on the first bit. Expect m_data=0xA5, m_corrected=0, err_count=0, m_valid one cycle after the last bit.
- Data error: CW0=7'h29 (bit 2 flipped), CW1=7'h52. Expect m_data=0xA5, m_corrected=1, err_count=1.
- Parity error in both codewords: CW0=7'h2C, CW1=7'h53. Expect m_data=0xA5, m_corrected=1, err_count=2.
- Backpressure:
  - Hold m_ready=0 across two frames 0xA5 and 0x5A. Expect m_data to stay 0xA5 and overflow=1.
  - Repeat with m_ready=1 on the second frame's last bit. Expect 0x5A to load with no overflow.
- Resync: assert s_sof at bit 3 of CW1, then send a full 0x5A frame. Expect a single resync pulse and only 0x5A delivered.
- Gaps and reset: insert s_valid=0 gaps inside a frame and expect an unchanged result. Assert rst at CW0 bit 4 and expect all outputs at reset values with no byte emitted.
